// File: rtl/axis_packet_fifo_pkg.sv
// Shared types for the AXI4-Stream packet FIFO.
//   axis_beat_t       : one 101-bit stream beat {tuser,tdest,tid,tlast,tkeep,tstrb,tdata},
//                       laid out the same way as the bridge flit payload
//   axis_fifo_state_t : release mode of the packet FIFO (STORE / CUT)
package axi4_pkg;

  localparam int AXI4S_BEAT_WIDTH = 101;

  typedef struct packed {
    logic [7:0]  tuser;
    logic [3:0]  tdest;
    logic [7:0]  tid;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [7:0]  tstrb;
    logic [63:0] tdata;
  } axis_beat_t;

  typedef enum logic {
    STORE = 1'b0,
    CUT   = 1'b1
  } axis_fifo_state_t;

endpackage

// File: rtl/axis_packet_fifo_if.sv
// AXI4-Stream bundle used on both sides of the packet FIFO.
//   master : drives beat fields and tvalid, samples tready
//   slave  : samples beat fields and tvalid, drives tready
interface axis_if;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic [7:0]  tkeep;
  logic        tlast;
  logic [7:0]  tid;
  logic [3:0]  tdest;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_fifo_mem.sv
// Beat storage for the packet FIFO: DEPTH x AXI4S_BEAT_WIDTH register array,
// one synchronous write port, one asynchronous read port (first-word fall-through).
//   CLK   : clock
//   we    : write enable
//   waddr : write index
//   wdata : beat to store
//   raddr : read index
//   rdata : beat at raddr, combinational
// Contents are deliberately not reset.
module axis_fifo_mem
  import axi4_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  axis_beat_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output axis_beat_t       rdata
);

  axis_beat_t mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI4-Stream FIFO in front of the NoC master bridge.
// A packet is only released once its tlast beat is stored, so the bridge never
// injects a partial packet. A packet longer than DEPTH switches the FIFO to
// cut-through (CUT) until that packet's tlast leaves, which avoids deadlock.
//   CLK, RST_N      : clock, synchronous active-low reset
//   s_axis          : upstream stream (slave side)
//   m_axis          : downstream stream to the bridge (master side, FWFT)
//   pkt_count       : complete packets (stored tlast beats) held
//   occupancy       : stored beats
// Optional (macro AXIS_PACKET_FIFO_STATS_EN):
//   stat_pkts_in    : saturating count of accepted tlast beats
//   stat_cut_events : saturating count of STORE->CUT transitions
module axis_packet_fifo
  import axi4_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST_N,
  axis_if.slave          s_axis,
  axis_if.master         m_axis,
  output logic [PTR_W:0] pkt_count,
  output logic [PTR_W:0] occupancy
`ifdef AXIS_PACKET_FIFO_STATS_EN
  ,
  output logic [31:0]    stat_pkts_in,
  output logic [31:0]    stat_cut_events
`endif
);

  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   pkt_count_q, pkt_count_d;
  axis_fifo_state_t state_q, state_d;

  logic       full, empty, wr_fire, rd_fire, cut_enter, tail_out;
  axis_beat_t wr_beat, rd_beat;

  // Pointers carry one extra MSB, so the plain difference is the fill level.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == OCC_FULL);
  assign empty     = (occupancy == '0);
  assign pkt_count = pkt_count_q;

  assign s_axis.tready = !full;
  assign m_axis.tvalid = !empty && ((state_q == CUT) || (pkt_count_q != '0));

  assign wr_fire  = s_axis.tvalid && s_axis.tready;
  assign rd_fire  = m_axis.tvalid && m_axis.tready;
  assign tail_out = rd_fire && rd_beat.tlast;

  // Full with no complete packet inside: the head packet cannot fit, stream it.
  assign cut_enter = (state_q == STORE) && full && (pkt_count_q == '0);

  assign wr_beat = '{tuser: s_axis.tuser, tdest: s_axis.tdest, tid: s_axis.tid,
                     tlast: s_axis.tlast, tkeep: s_axis.tkeep, tstrb: s_axis.tstrb,
                     tdata: s_axis.tdata};

  axis_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK   (CLK),
    .we    (wr_fire),
    .waddr (wr_ptr_q[PTR_W-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (rd_beat)
  );

  assign m_axis.tdata = rd_beat.tdata;
  assign m_axis.tstrb = rd_beat.tstrb;
  assign m_axis.tkeep = rd_beat.tkeep;
  assign m_axis.tlast = rd_beat.tlast;
  assign m_axis.tid   = rd_beat.tid;
  assign m_axis.tdest = rd_beat.tdest;
  assign m_axis.tuser = rd_beat.tuser;

  always_comb begin
    wr_ptr_d    = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    pkt_count_d = pkt_count_q;
    case ({wr_fire && s_axis.tlast, tail_out})
      2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
      2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
    state_d = state_q;
    case (state_q)
      STORE:   if (cut_enter) state_d = CUT;
      CUT:     if (tail_out)  state_d = STORE;
      default: state_d = STORE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      state_q     <= STORE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
    end
  end

`ifdef AXIS_PACKET_FIFO_STATS_EN
  logic [31:0] stat_pkts_in_q, stat_pkts_in_d;
  logic [31:0] stat_cut_events_q, stat_cut_events_d;

  always_comb begin
    stat_pkts_in_d    = stat_pkts_in_q;
    stat_cut_events_d = stat_cut_events_q;
    if (wr_fire && s_axis.tlast && (stat_pkts_in_q != 32'hFFFF_FFFF))
      stat_pkts_in_d = stat_pkts_in_q + 32'd1;
    if (cut_enter && (stat_cut_events_q != 32'hFFFF_FFFF))
      stat_cut_events_d = stat_cut_events_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_pkts_in_q    <= '0;
      stat_cut_events_q <= '0;
    end else begin
      stat_pkts_in_q    <= stat_pkts_in_d;
      stat_cut_events_q <= stat_cut_events_d;
    end
  end

  assign stat_pkts_in    = stat_pkts_in_q;
  assign stat_cut_events = stat_cut_events_q;
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo (DEPTH=16). Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge. A scoreboard queue
// receives every accepted input beat and is compared against every output beat.
module tb_axis_packet_fifo;
  import axi4_pkg::*;

  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [4:0] pkt_count, occupancy;
`ifdef AXIS_PACKET_FIFO_STATS_EN
  logic [31:0] stat_pkts_in, stat_cut_events;
`endif

  axis_if s_if ();
  axis_if m_if ();

  always #5 CLK = ~CLK;

  axis_packet_fifo #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .pkt_count (pkt_count),
    .occupancy (occupancy)
`ifdef AXIS_PACKET_FIFO_STATS_EN
    ,
    .stat_pkts_in    (stat_pkts_in),
    .stat_cut_events (stat_cut_events)
`endif
  );

  typedef struct {
    logic        sv;
    logic [63:0] d;
    logic        sl;
    logic        mr;
    logic        e_mv;
    logic        e_sr;
    logic [4:0]  e_occ;
    logic [4:0]  e_pc;
  } vec_t;

  vec_t       tbl [9];
  axis_beat_t sb [$];
  int         errors = 0;
  int         checks = 0;
  int         rx_count = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: pop/compare on output fire, then push on input fire.
  task automatic monitor();
    axis_beat_t got, exp;
    forever begin
      @(negedge CLK);
      if (!RST_N) sb.delete();
      else begin
        if (m_if.tvalid && m_if.tready) begin
          got = {m_if.tuser, m_if.tdest, m_if.tid, m_if.tlast,
                 m_if.tkeep, m_if.tstrb, m_if.tdata};
          rx_count++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none", got);
          end else begin
            exp = sb.pop_front();
            chk("out_beat", 128'(got), 128'(exp));
          end
        end
        if (s_if.tvalid && s_if.tready)
          sb.push_back({s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast,
                        s_if.tkeep, s_if.tstrb, s_if.tdata});
      end
    end
  endtask

  function automatic axis_beat_t mk(input logic [63:0] d, input logic l);
    axis_beat_t b;
    b = '{tuser: 8'h00, tdest: 4'h0, tid: 8'h00, tlast: l,
          tkeep: 8'hFF, tstrb: 8'hFF, tdata: d};
    return b;
  endfunction

  // Present a beat and hold it until accepted (bounded).
  task automatic put(input axis_beat_t b);
    bit ok;
    ok = 1'b0;
    {s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast,
     s_if.tkeep, s_if.tstrb, s_if.tdata} = b;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (s_if.tready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: got tready=0 expected tready=1");
    end
    step();
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (occupancy == 5'd0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, 128'(ok), 128'(1'b1));
    step();
  endtask

  initial begin
    int rx0;
    bit done;
    s_if.tvalid = 1'b0;
    {s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast,
     s_if.tkeep, s_if.tstrb, s_if.tdata} = '0;
    m_if.tready = 1'b1;
    fork monitor(); join_none

    //            sv    data     sl    mr    mv    sr    occ   pc
    tbl[0] = '{1'b1, 64'h10, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0};
    tbl[1] = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd0};
    tbl[2] = '{1'b1, 64'h12, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0};
    tbl[3] = '{1'b1, 64'h13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0};
    tbl[4] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd1};
    tbl[5] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1};
    tbl[6] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd1};
    tbl[7] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd1};
    tbl[8] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0};

    repeat (3) step();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_tready", 128'(s_if.tready), 128'(1'b1));
    chk("rst_tvalid", 128'(m_if.tvalid), 128'(1'b0));
    chk("rst_occ",    128'(occupancy),   128'(5'd0));
    chk("rst_pkt",    128'(pkt_count),   128'(5'd0));
    step();

    // Store-and-forward holdback, cycle by cycle.
    for (int i = 0; i < 9; i++) begin
      s_if.tvalid = tbl[i].sv;
      s_if.tdata  = tbl[i].d;
      s_if.tlast  = tbl[i].sl;
      s_if.tkeep  = 8'hFF;
      s_if.tstrb  = 8'hFF;
      m_if.tready = tbl[i].mr;
      @(negedge CLK);
      chk($sformatf("hb%0d_mvalid", i), 128'(m_if.tvalid), 128'(tbl[i].e_mv));
      chk($sformatf("hb%0d_sready", i), 128'(s_if.tready), 128'(tbl[i].e_sr));
      chk($sformatf("hb%0d_occ", i),    128'(occupancy),   128'(tbl[i].e_occ));
      chk($sformatf("hb%0d_pkt", i),    128'(pkt_count),   128'(tbl[i].e_pc));
      step();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // Overflow to CUT.
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) put(mk(64'h100 + 64'(i), 1'b0));
    @(negedge CLK);
    chk("ovf_sready_full", 128'(s_if.tready), 128'(1'b0));
    chk("ovf_occ_full",    128'(occupancy),   128'(5'd16));
    step();
    @(negedge CLK);
    chk("ovf_cut_mvalid", 128'(m_if.tvalid), 128'(1'b1));
    chk("ovf_cut_pkt",    128'(pkt_count),   128'(5'd0));
    step();
    m_if.tready = 1'b1;
    for (int i = 16; i < 20; i++) put(mk(64'h100 + 64'(i), i == 19));
    wait_empty("ovf_drain");
    chk("ovf_pkt_after", 128'(pkt_count), 128'(5'd0));
    // Back in STORE: a lone non-tlast beat must be held.
    put(mk(64'h200, 1'b0));
    @(negedge CLK);
    chk("store_again_hold", 128'(m_if.tvalid), 128'(1'b0));
    step();
    put(mk(64'h201, 1'b1));
    wait_empty("short1_drain");
    put(mk(64'h300, 1'b1));
    put(mk(64'h301, 1'b1));
    wait_empty("short23_drain");
`ifdef AXIS_PACKET_FIFO_STATS_EN
    @(negedge CLK);
    chk("stat_pkts_in",    128'(stat_pkts_in),    128'(32'd4));
    chk("stat_cut_events", 128'(stat_cut_events), 128'(32'd1));
    step();
`endif

    // Simultaneous read/write at occupancy 5.
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) put(mk(64'h400 + 64'(i), i == 4));
    @(negedge CLK);
    chk("sim_occ_start", 128'(occupancy), 128'(5'd5));
    chk("sim_pkt_start", 128'(pkt_count), 128'(5'd1));
    step();
    for (int i = 0; i < 10; i++) begin
      {s_if.tuser, s_if.tdest, s_if.tid, s_if.tlast,
       s_if.tkeep, s_if.tstrb, s_if.tdata} = mk(64'h500 + 64'(i), 1'b1);
      s_if.tvalid = 1'b1;
      m_if.tready = 1'b1;
      @(negedge CLK);
      chk($sformatf("sim%0d_occ", i), 128'(occupancy), 128'(5'd5));
      chk($sformatf("sim%0d_both", i), 128'(m_if.tvalid && s_if.tready), 128'(1'b1));
      step();
    end
    s_if.tvalid = 1'b0;
    wait_empty("sim_drain");

    // Pointer wrap with random backpressure and random side fields.
    rx0  = rx_count;
    done = 1'b0;
    fork
      begin
        axis_beat_t b;
        for (int i = 0; i < 100; i++) begin
          b = '{tuser: 8'($urandom), tdest: 4'($urandom), tid: 8'($urandom),
                tlast: 1'b1, tkeep: 8'($urandom), tstrb: 8'($urandom),
                tdata: 64'(i)};
          put(b);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_if.tready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    m_if.tready = 1'b1;
    wait_empty("wrap_drain");
    chk("wrap_rx_count", 128'(rx_count - rx0), 128'(100));

    // Reset mid-packet discards partial packet.
    for (int i = 0; i < 3; i++) put(mk(64'h600 + 64'(i), 1'b0));
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mrst_occ",    128'(occupancy),   128'(5'd0));
    chk("mrst_mvalid", 128'(m_if.tvalid), 128'(1'b0));
    chk("mrst_sready", 128'(s_if.tready), 128'(1'b1));
    step();
    rx0 = rx_count;
    put(mk(64'h700, 1'b0));
    put(mk(64'h701, 1'b1));
    wait_empty("mrst_drain");
    chk("mrst_rx_count", 128'(rx_count - rx0), 128'(2));
    chk("sb_empty_end", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
